// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: shared states, engine port map, byte constants and error codes for the SD SPI sequencer
package sd_spi_pkg;
  typedef enum logic [3:0] {
    INIT, IDLE, SET_DIV, CS_ON, CMD, WAIT_R1, WAIT_TOKEN, DATA, CRC, CS_OFF, TRAIL, DONE
  } state_e;
  localparam logic [11:0] ADDR_CS   = 12'h0B0;
  localparam logic [11:0] ADDR_DIV  = 12'h0B1;
  localparam logic [11:0] ADDR_DATA = 12'h0B2;
  localparam logic [7:0] DATA_TOKEN = 8'hFE;
  localparam logic [7:0] FILL       = 8'hFF;
  localparam logic [2:0] ERR_OK      = 3'd0;
  localparam logic [2:0] ERR_R1_TO   = 3'd1;
  localparam logic [2:0] ERR_TOK_TO  = 3'd2;
  localparam logic [2:0] ERR_BAD_TOK = 3'd3;
  localparam logic [2:0] ERR_R1_NZ   = 3'd4;
  // Byte n (0..5) of the 6-byte SD command frame.
  function automatic logic [7:0] cmd_byte(input logic [2:0] n, input logic [5:0] idx,
                                          input logic [31:0] arg, input logic [7:0] crc);
    return n == 3'd0 ? {2'b01, idx} :
           n == 3'd1 ? arg[31:24] :
           n == 3'd2 ? arg[23:16] :
           n == 3'd3 ? arg[15:8] :
           n == 3'd4 ? arg[7:0] : crc;
  endfunction
endpackage

// File: rtl/spi_byte_xchg.sv
// spi_byte_xchg: owns the engine I/O port; does raw register writes and write/gap/wait-ready byte exchanges
// Ports: clk, reset_n (sync, active low); go/tx start a byte exchange, wr/waddr/wdat do a single
// register write; busy, rx, rx_valid report the exchange; spi_* is the registered engine port.
module spi_byte_xchg
  import sd_spi_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        go,
  input  logic [7:0]  tx,
  input  logic        wr,
  input  logic [11:0] waddr,
  input  logic [7:0]  wdat,
  output logic        busy,
  output logic [7:0]  rx,
  output logic        rx_valid,
  output logic [11:0] spi_ioaddr,
  output logic [7:0]  spi_din,
  output logic        spi_iowr,
  input  logic [7:0]  spi_dout,
  input  logic        spi_ready
);
  typedef enum logic [1:0] {X_IDLE, X_WR, X_GAP, X_WAIT} xstate_e;
  xstate_e     st_q;
  logic [11:0] ioaddr_q;
  logic [7:0]  din_q, rx_q;
  logic        iowr_q, rxv_q;
  // The engine only drops ready after it has seen the write, so X_WR and X_GAP never sample it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st_q     <= X_IDLE;
      ioaddr_q <= ADDR_CS;
      din_q    <= 8'h00;
      iowr_q   <= 1'b0;
      rx_q     <= 8'h00;
      rxv_q    <= 1'b0;
    end else begin
      iowr_q <= 1'b0;
      rxv_q  <= 1'b0;
      case (st_q)
        X_IDLE:
          if (wr) begin
            iowr_q   <= 1'b1;
            ioaddr_q <= waddr;
            din_q    <= wdat;
          end else if (go) begin
            iowr_q   <= 1'b1;
            ioaddr_q <= ADDR_DATA;
            din_q    <= tx;
            st_q     <= X_WR;
          end
        X_WR:  st_q <= X_GAP;
        X_GAP: st_q <= X_WAIT;
        default:
          if (spi_ready) begin
            rx_q  <= spi_dout;
            rxv_q <= 1'b1;
            st_q  <= X_IDLE;
          end
      endcase
    end
  end
  assign busy       = st_q != X_IDLE;
  assign rx         = rx_q;
  assign rx_valid   = rxv_q;
  assign spi_ioaddr = ioaddr_q;
  assign spi_din    = din_q;
  assign spi_iowr   = iowr_q;
endmodule

// File: rtl/sd_spi_sequencer.sv
// sd_spi_sequencer: autonomous SD command + single block read sequencer over the SPI byte engine port
// Ports: clk, reset_n (sync, active low); start + cmd_index/cmd_arg/cmd_crc/rd_block/clk_div request a
// transaction; busy/done/r1/err report it; data_valid/data_byte/data_idx stream the block;
// spi_ioaddr/spi_din/spi_iowr/spi_dout/spi_ready connect to the byte engine.
module sd_spi_sequencer
  import sd_spi_pkg::*;
#(
  parameter int R1_TRIES    = 8,
  parameter int TOKEN_TRIES = 4096,
  parameter int BLOCK_BYTES = 512
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [7:0]  cmd_crc,
  input  logic        rd_block,
  input  logic [7:0]  clk_div,
  output logic        busy,
  output logic        done,
  output logic [7:0]  r1,
  output logic [2:0]  err,
  output logic        data_valid,
  output logic [7:0]  data_byte,
  output logic [8:0]  data_idx,
  output logic [11:0] spi_ioaddr,
  output logic [7:0]  spi_din,
  output logic        spi_iowr,
  input  logic [7:0]  spi_dout,
  input  logic        spi_ready
);
  state_e      state_q;
  logic [12:0] cnt_q;
  logic [5:0]  idx_q;
  logic [31:0] arg_q;
  logic [7:0]  crc_q, div_q, r1_q, db_q;
  logic        rd_q, busy_q, done_q, dv_q;
  logic [2:0]  err_q;
  logic [8:0]  didx_q;
  logic        xfer, go, wr, x_busy, x_rxv;
  logic [7:0]  tx, wdat, x_rx;
  logic [11:0] waddr;
  // go is held off while the exchanger reports a byte (state is still being updated) and in the
  // cycle right after a raw CS write, so 0x0B2 writes never follow another write back to back.
  always_comb begin
    xfer  = state_q inside {CMD, WAIT_R1, WAIT_TOKEN, DATA, CRC, TRAIL};
    go    = xfer && !x_busy && !x_rxv && !spi_iowr;
    tx    = (state_q == CMD) ? cmd_byte(cnt_q[2:0], idx_q, arg_q, crc_q) : FILL;
    wr    = state_q inside {INIT, SET_DIV, CS_ON, CS_OFF};
    waddr = (state_q == SET_DIV) ? ADDR_DIV : ADDR_CS;
    wdat  = (state_q == SET_DIV) ? div_q : {7'd0, state_q == CS_ON};
  end
  spi_byte_xchg u_xchg (
    .clk        (clk),
    .reset_n    (reset_n),
    .go         (go),
    .tx         (tx),
    .wr         (wr),
    .waddr      (waddr),
    .wdat       (wdat),
    .busy       (x_busy),
    .rx         (x_rx),
    .rx_valid   (x_rxv),
    .spi_ioaddr (spi_ioaddr),
    .spi_din    (spi_din),
    .spi_iowr   (spi_iowr),
    .spi_dout   (spi_dout),
    .spi_ready  (spi_ready)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
      idx_q   <= '0;
      arg_q   <= '0;
      crc_q   <= '0;
      rd_q    <= 1'b0;
      div_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      r1_q    <= 8'hFF;
      err_q   <= ERR_OK;
      dv_q    <= 1'b0;
      db_q    <= '0;
      didx_q  <= '0;
    end else begin
      done_q <= 1'b0;
      dv_q   <= 1'b0;
      case (state_q)
        INIT: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        IDLE, DONE: begin
          state_q <= IDLE;
          if (start) begin
            idx_q   <= cmd_index;
            arg_q   <= cmd_arg;
            crc_q   <= cmd_crc;
            rd_q    <= rd_block;
            div_q   <= clk_div;
            err_q   <= ERR_OK;
            busy_q  <= 1'b1;
            state_q <= SET_DIV;
          end
        end
        SET_DIV: state_q <= CS_ON;
        CS_ON: begin
          cnt_q   <= '0;
          state_q <= CMD;
        end
        CMD:
          if (x_rxv) begin
            cnt_q <= cnt_q + 13'd1;
            if (cnt_q == 13'd5) begin
              cnt_q   <= '0;
              state_q <= WAIT_R1;
            end
          end
        WAIT_R1:
          if (x_rxv) begin
            r1_q  <= x_rx;
            cnt_q <= cnt_q + 13'd1;
            if (!x_rx[7]) begin
              cnt_q   <= '0;
              state_q <= (rd_q && x_rx == 8'h00) ? WAIT_TOKEN : CS_OFF;
              err_q   <= (rd_q && x_rx != 8'h00) ? ERR_R1_NZ : ERR_OK;
            end else if (cnt_q == 13'(R1_TRIES - 1)) begin
              err_q   <= ERR_R1_TO;
              state_q <= CS_OFF;
            end
          end
        WAIT_TOKEN:
          if (x_rxv) begin
            cnt_q <= cnt_q + 13'd1;
            if (x_rx == DATA_TOKEN) begin
              cnt_q   <= '0;
              state_q <= DATA;
            end else if (x_rx != FILL) begin
              err_q   <= ERR_BAD_TOK;
              state_q <= CS_OFF;
            end else if (cnt_q == 13'(TOKEN_TRIES - 1)) begin
              err_q   <= ERR_TOK_TO;
              state_q <= CS_OFF;
            end
          end
        DATA:
          if (x_rxv) begin
            dv_q   <= 1'b1;
            db_q   <= x_rx;
            didx_q <= cnt_q[8:0];
            cnt_q  <= cnt_q + 13'd1;
            if (cnt_q == 13'(BLOCK_BYTES - 1)) begin
              cnt_q   <= '0;
              state_q <= CRC;
            end
          end
        CRC:
          if (x_rxv) begin
            cnt_q <= cnt_q + 13'd1;
            if (cnt_q == 13'd1) state_q <= CS_OFF;
          end
        CS_OFF: state_q <= TRAIL;
        TRAIL:
          if (x_rxv) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        default: state_q <= INIT;
      endcase
    end
  end
  assign busy       = busy_q;
  assign done       = done_q;
  assign r1         = r1_q;
  assign err        = err_q;
  assign data_valid = dv_q;
  assign data_byte  = db_q;
  assign data_idx   = didx_q;
endmodule
